i2c_eeprom_slave: RTL and testbench
===================================

# i2c_eeprom_slave

I2C target that behaves like a 256-byte serial EEPROM (7-bit device address 1010_000). It answers the same traffic our EEPROM-master block generates: byte write, sequential write, random read and sequential read. It is the on-FPGA stand-in for the external EEPROM, used in loop-back self-tests and on boards without the part fitted. It sits on the shared scl/sda pins, alongside the master.

## Interface
- DEV_ADDR, 7'b1010000, 7-bit device address the block acknowledges
- MEM_INIT, 8'hFF, value loaded into every memory byte at reset
- clk  input  1  system clock; must be at least 8× the scl frequency
- rstn  input  1  reset, asynchronous, active-low
- scl  input  1  I2C clock from the master; the block never stretches it
- sda  inout  1  I2C data, open-drain: driven 1'b0 when sda_oe=1, otherwise 1'bz
- busy  output  1  high from a START detect to the next STOP detect; reset 0
- wr_strobe  output  1  one-clk pulse per byte written to memory; reset 0
- wr_addr  output  8  memory address of the last write; reset 0
- wr_data  output  8  data of the last write; reset 0

## Operation
- **Input conditioning**
  - scl and sda each pass through 2-flop synchronizers plus one history flop.
  - scl_rise / scl_fall are edges of the synced scl.
  - START = synced sda falls while synced scl = 1.
  - STOP = synced sda rises while synced scl = 1.
- **Priority and global rules**
  - START and STOP override every state.
  - START (including repeated START) → DEV, bit counter = 0, busy = 1.
  - STOP → IDLE, sda_oe = 0, busy = 0.
- **Bit transfer**
  - Received bits are shifted in MSB-first on scl_rise.
  - sda_oe changes only on scl_fall.
- **State machine**
  - IDLE: sda released; waits for START.
  - DEV: shifts in 8 bits.
    - On the 8th scl_rise: if bits[7:1] == DEV_ADDR → DEV_ACK, latch rw = bit[0].
    - Otherwise → IDLE with no ACK (sda stays released until the next START).
  - DEV_ACK: sda_oe = 1 for one scl low+high period. On the closing scl_fall:
    - rw = 0 → ADDR.
    - rw = 1 → RDATA; load the shifter with mem[ptr]; drive bit 7.
  - ADDR: shifts in 8 bits into ptr → ADDR_ACK. ACK as in DEV_ACK, then → WDATA.
  - WDATA: shifts in 8 bits → WDATA_ACK.
    - On the 8th scl_rise: mem[ptr] ← byte, wr_addr ← ptr, wr_data ← byte, wr_strobe pulses.
    - Then ptr ← ptr + 1, mod 256 (0xFF wraps to 0x00).
  - WDATA_ACK: ACK, then → WDATA. Further bytes are a sequential write; this continues until STOP or START.
  - RDATA: on each scl_fall, sda_oe = ~shifter[7] and the shifter shifts left.
    - After the 8th bit's scl_fall, sda is released.
    - ptr ← ptr + 1, mod 256. → RACK.
  - RACK: sample synced sda on scl_rise.
    - 0 (master ACK) → RDATA with mem[ptr] loaded; its first bit is driven on the next scl_fall.
    - 1 (NOACK) → WAIT_STOP with sda released.
  - WAIT_STOP: ignores scl; leaves only on START or STOP.
- **Random read** = write header (DEV, ADDR) + repeated START + read header. ptr set by ADDR is preserved across the repeated START.
- **Reset**
  - Asynchronously: state IDLE, sda_oe = 0 (sda released immediately), ptr = 0, all outputs 0, every memory byte = MEM_INIT.
  - Reset mid-transfer aborts it; no partial write is committed.
- **Memory:** 256×8 register array, single write port, combinational read by ptr.

## Timing
- Pin-to-action latency is 3 clk: 2 sync + 1 registered.
  - sda_oe changes 3 clk after the scl pin falls.
  - This lands well inside scl low, since the master moves sda 7 clk after the scl fall on a 30-clk bit period.
- Receive sample point: 3 clk after the scl pin rises.
- ACK: sda low from the scl_fall after the 8th bit rise to the following scl_fall.
- wr_strobe is high in the clk after the 8th data-bit scl_rise is detected. wr_addr and wr_data are valid from that same clk and hold until the next write.
- Simultaneous START and scl edge in one clk is impossible by definition (scl is stable high). A START/STOP detect takes precedence over the bit logic in the same clk.

## Test plan
- **Byte write:** START, 0xA0, 0x05, 0x3C, STOP.
  - ACK low on all 3 ACK slots.
  - One wr_strobe with wr_addr = 0x05, wr_data = 0x3C.
  - busy falls 3 clk after STOP.
- **Random read after reset:** START, 0xA0, 0x10, START, 0xA1, read 1 byte, NOACK, STOP.
  - Returns 0xFF.
  - After a prior write of 0x3C to 0x05, the same sequence at address 0x05 returns 0x3C.
- **Wrong device address:** 0xA4 (1010_010).
  - No ACK (sda stays 1); state returns to IDLE; no wr_strobe.
  - A following valid frame is ACKed normally.
- **Sequential write with wrap:** address 0xFF, data 0x11, 0x22.
  - mem[0xFF] = 0x11, mem[0x00] = 0x22; two wr_strobes.
  - A sequential read from 0xFF with ACK, then NOACK, returns 0x11 then 0x22.
- **STOP mid-byte:** STOP after 4 data bits.
  - No write; state IDLE; sda released.
- **Reset mid-transfer:** assert rstn while the slave drives a 0 data bit.
  - sda goes Z asynchronously; busy = 0; memory returns to 0xFF.

Source files
------------

// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 256-byte serial EEPROM on the shared scl/sda pins.
// Handles byte/sequential write plus random, current-address and sequential read.
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'b1010000,
  parameter logic [7:0] MEM_INIT = 8'hFF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_ADDR      = 4'd3,
    ST_ADDR_ACK  = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  logic       scl_s1_q, scl_s2_q, scl_h_q;
  logic       sda_s1_q, sda_s2_q, sda_h_q;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       ack_drv_q, ack_drv_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] mem_q [256];

  logic       scl_rise, scl_fall, start_det, stop_det, mem_we;
  logic [7:0] rx_byte, mem_rd;

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & ~sda_h_q & sda_s2_q;
  assign rx_byte   = {rx_q[6:0], sda_s2_q};
  assign mem_rd    = mem_q[ptr_q];

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  // Next-state logic: bus conditions first, then the per-state bit handling
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_drv_d   = ack_drv_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    if (start_det) begin
      state_d   = ST_DEV;
      cnt_d     = 4'd0;
      busy_d    = 1'b1;
      sda_oe_d  = 1'b0;
      ack_drv_d = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
    end else begin
      if (scl_rise) begin
        rx_d = rx_byte;
      end else begin
        rx_d = rx_q;
      end
      case (state_q)
        ST_IDLE, ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        ST_DEV, ST_ADDR, ST_WDATA: begin
          if (scl_rise && cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (state_q == ST_DEV) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d = ST_DEV_ACK;
                rw_d    = rx_byte[0];
              end else begin
                state_d = ST_IDLE;
              end
            end else if (state_q == ST_ADDR) begin
              ptr_d   = rx_byte;
              state_d = ST_ADDR_ACK;
            end else begin
              mem_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = rx_byte;
              ptr_d       = ptr_q + 8'd1;
              state_d     = ST_WDATA_ACK;
            end
          end else if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end
        // ACK slot: pull low on the first fall, release and move on at the next
        ST_DEV_ACK, ST_ADDR_ACK, ST_WDATA_ACK: begin
          if (scl_fall && !ack_drv_q) begin
            sda_oe_d  = 1'b1;
            ack_drv_d = 1'b1;
          end else if (scl_fall) begin
            ack_drv_d = 1'b0;
            cnt_d     = 4'd0;
            if (state_q == ST_DEV_ACK && rw_q) begin
              state_d  = ST_RDATA;
              sda_oe_d = ~mem_rd[7];
              tx_d     = {mem_rd[6:0], 1'b0};
              cnt_d    = 4'd1;
            end else if (state_q == ST_DEV_ACK) begin
              state_d  = ST_ADDR;
              sda_oe_d = 1'b0;
            end else begin
              state_d  = ST_WDATA;
              sda_oe_d = 1'b0;
            end
          end else begin
            ack_drv_d = ack_drv_q;
          end
        end
        ST_RDATA: begin
          if (scl_fall && cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + 8'd1;
            cnt_d    = 4'd0;
            state_d  = ST_RACK;
          end else if (scl_fall) begin
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
            cnt_d    = cnt_q + 4'd1;
          end else begin
            tx_d = tx_q;
          end
        end
        ST_RACK: begin
          if (scl_rise && !sda_s2_q) begin
            state_d = ST_RDATA;
            tx_d    = mem_rd;
            cnt_d   = 4'd0;
          end else if (scl_rise) begin
            state_d = ST_WAIT_STOP;
          end else begin
            state_d = ST_RACK;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Pin synchronizers and all control/output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_h_q     <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_h_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rx_q        <= 8'd0;
      tx_q        <= 8'd0;
      ptr_q       <= 8'd0;
      rw_q        <= 1'b0;
      ack_drv_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
    end else begin
      scl_s1_q    <= scl;
      scl_s2_q    <= scl_s1_q;
      scl_h_q     <= scl_s2_q;
      sda_s1_q    <= sda;
      sda_s2_q    <= sda_s1_q;
      sda_h_q     <= sda_s2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_drv_q   <= ack_drv_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Storage array: filled with MEM_INIT on reset, one write port at ptr
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) begin
        mem_q[i] <= MEM_INIT;
      end
    end else if (mem_we) begin
      mem_q[ptr_q] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bit-level I2C master driving directed and random EEPROM traffic, checked
// against a byte-level memory/pointer model and a per-cycle output compare.
module tb_i2c_eeprom_slave;

  localparam logic [6:0] DEV = 7'b1010000;
  localparam logic [7:0] HDR_W = {DEV, 1'b0};
  localparam logic [7:0] HDR_R = {DEV, 1'b1};

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       busy, wr_strobe;
  logic [7:0] wr_addr, wr_data;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_eeprom_slave #(.DEV_ADDR(DEV), .MEM_INIT(8'hFF)) dut (
    .clk(clk), .rstn(rstn), .scl(scl), .sda(sda),
    .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         fails = 0;
  logic [7:0] mdl_mem [256];
  logic [7:0] mdl_ptr = 8'd0;
  logic [15:0] exp_wr_q [$];
  logic [7:0] exp_last_addr = 8'd0;
  logic [7:0] exp_last_data = 8'd0;
  logic       m_busy = 1'b0;
  logic [3:0] busy_hist = 4'd0;
  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle output compare: write events, held write registers, busy latency
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rstn) busy_hist = 4'd0;
      else busy_hist = {busy_hist[2:0], m_busy};
      if (wr_strobe === 1'b1 && exp_wr_q.size() == 0) begin
        check("wr_strobe_unexpected", 32'(wr_strobe), 32'd0);
      end else if (wr_strobe === 1'b1) begin
        e = exp_wr_q.pop_front();
        exp_last_addr = e[15:8];
        exp_last_data = e[7:0];
        check("wr_addr", 32'(wr_addr), 32'(exp_last_addr));
        check("wr_data", 32'(wr_data), 32'(exp_last_data));
      end else begin
        check("wr_addr_hold", 32'(wr_addr), 32'(exp_last_addr));
        check("wr_data_hold", 32'(wr_data), 32'(exp_last_data));
      end
      check("busy", 32'(busy), 32'(busy_hist[3]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    tick(7); m_low = ~b; tick(8); scl = 1'b1; tick(15); scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    tick(7); m_low = 1'b0; tick(8); scl = 1'b1; tick(8); b = sda; tick(7); scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      tick(7); m_low = 1'b0; tick(8); scl = 1'b1; tick(8);
    end
    m_low = 1'b1; m_busy = 1'b1; tick(8); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(7); m_low = 1'b1; tick(8); scl = 1'b1; tick(8); m_low = 1'b0; m_busy = 1'b0; tick(10);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string nm);
    logic a;
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(a);
    check(nm, 32'(a), 32'(exp_ack));
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(nack);
  endtask

  task automatic do_write(input logic [7:0] addr, input int n);
    i2c_start();
    send_byte(HDR_W, 1'b0, "ack_dev_w");
    send_byte(addr, 1'b0, "ack_addr");
    mdl_ptr = addr;
    for (int k = 0; k < n; k++) begin
      exp_wr_q.push_back({mdl_ptr, wbuf[k]});
      mdl_mem[mdl_ptr] = wbuf[k];
      mdl_ptr = mdl_ptr + 8'd1;
      send_byte(wbuf[k], 1'b0, "ack_wdata");
    end
    i2c_stop();
    check("writes_pending", 32'(exp_wr_q.size()), 32'd0);
  endtask

  task automatic do_read(input logic use_addr, input logic [7:0] addr, input int n);
    i2c_start();
    if (use_addr) begin
      send_byte(HDR_W, 1'b0, "ack_dev_w");
      send_byte(addr, 1'b0, "ack_addr");
      mdl_ptr = addr;
      i2c_start();
    end
    send_byte(HDR_R, 1'b0, "ack_dev_r");
    for (int k = 0; k < n; k++) begin
      recv_byte(rbuf[k], (k == n - 1));
      check("rd_data", 32'(rbuf[k]), 32'(mdl_mem[mdl_ptr]));
      mdl_ptr = mdl_ptr + 8'd1;
    end
    i2c_stop();
  endtask

  task automatic bad_dev(input logic [7:0] hdr);
    i2c_start();
    send_byte(hdr, 1'b1, "nack_bad_dev");
    send_byte(8'h55, 1'b1, "nack_after_bad_dev");
    i2c_stop();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'hFF;
    mdl_ptr = 8'd0;
    exp_wr_q.delete();
    exp_last_addr = 8'd0;
    exp_last_data = 8'd0;
    m_busy = 1'b0;
  endtask

  task automatic rand_txn();
    int kind, n;
    logic [7:0] a;
    logic [6:0] bad;
    kind = $urandom_range(0, 9);
    n = $urandom_range(1, 3);
    a = 8'($urandom_range(0, 255));
    if (kind <= 3) begin
      for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom_range(0, 255));
      do_write(a, n);
    end else if (kind <= 6) begin
      do_read(1'b1, a, n);
    end else if (kind <= 8) begin
      do_read(1'b0, 8'd0, n);
    end else begin
      bad = 7'($urandom_range(0, 127));
      if (bad == DEV) bad = bad ^ 7'h01;
      bad_dev({bad, a[0]});
    end
  endtask

  initial begin
    #2 rstn = 1'b0;
    model_reset();
    tick(4);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    rstn = 1'b1;
    tick(4);

    // Byte write then random reads
    wbuf[0] = 8'h3C;
    do_write(8'h05, 1);
    check("bw_wr_addr", 32'(wr_addr), 32'h05);
    check("bw_wr_data", 32'(wr_data), 32'h3C);
    check("bw_busy_after_stop", 32'(busy), 32'd0);
    do_read(1'b1, 8'h10, 1);
    check("rd_erased", 32'(rbuf[0]), 32'hFF);
    do_read(1'b1, 8'h05, 1);
    check("rd_written", 32'(rbuf[0]), 32'h3C);

    // Wrong device address, then a valid frame
    bad_dev(8'hA4);
    do_read(1'b1, 8'h05, 1);
    check("rd_after_bad_dev", 32'(rbuf[0]), 32'h3C);

    // Sequential write wrapping 0xFF -> 0x00, read back across the wrap
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    do_write(8'hFF, 2);
    do_read(1'b1, 8'hFF, 2);
    check("wrap_rd0", 32'(rbuf[0]), 32'h11);
    check("wrap_rd1", 32'(rbuf[1]), 32'h22);

    // STOP after four data bits: nothing committed
    i2c_start();
    send_byte(HDR_W, 1'b0, "ack_dev_w");
    send_byte(8'h20, 1'b0, "ack_addr");
    mdl_ptr = 8'h20;
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    i2c_stop();
    check("midbyte_sda_released", 32'(sda), 32'd1);
    do_read(1'b1, 8'h20, 1);
    check("midbyte_no_write", 32'(rbuf[0]), 32'hFF);

    for (int t = 0; t < 24; t++) rand_txn();

    // Reset while the slave drives a 0 data bit (bit 7 of 0x3C)
    wbuf[0] = 8'h3C;
    do_write(8'h05, 1);
    i2c_start();
    send_byte(HDR_W, 1'b0, "ack_dev_w");
    send_byte(8'h05, 1'b0, "ack_addr");
    i2c_start();
    send_byte(HDR_R, 1'b0, "ack_dev_r");
    tick(5);
    check("slave_drives_zero", 32'(sda), 32'd0);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    check("async_rst_sda_released", 32'(sda), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    tick(3);
    scl = 1'b1;
    m_low = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(5);
    do_read(1'b1, 8'h05, 1);
    check("mem_reinit_05", 32'(rbuf[0]), 32'hFF);
    do_read(1'b1, 8'hFF, 1);
    check("mem_reinit_ff", 32'(rbuf[0]), 32'hFF);

    check("writes_pending_end", 32'(exp_wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
